raygroup_dispatch_arbiter: RTL and testbench

Shares one upstream ray-group request stream between the two intersection-unit channels, unit 01 and unit 10, of the ray generator. It grants requests round-robin, drives the one-cycle `raygroupvalid` dispatch pulses and tracks each unit's in-flight job. A job closes on a result return (`rgResultReady`/`rgResultSource`) or a watchdog timeout. The block sits between the ray-group producer and the `raygroup01`/`raygroup10` ports of the top level.

---
 rtl/raygroup_dispatch_arbiter.sv | 137 +++++++++++++
 tb/tb_raygroup_dispatch_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/raygroup_dispatch_arbiter.sv
// rtl/raygroup_dispatch_arbiter.sv - round-robin ray-group dispatch to units 01/10 with holdoff and watchdog
module raygroup_dispatch_arbiter #(
  parameter int HOLDOFF = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        req_valid,
  input  logic [1:0]  req_group,
  output logic        req_ready,
  output logic [1:0]  raygroup01,
  output logic        raygroupvalid01,
  input  logic        busy01,
  output logic [1:0]  raygroup10,
  output logic        raygroupvalid10,
  input  logic        busy10,
  input  logic        rgResultReady,
  input  logic [1:0]  rgResultSource,
  output logic        idle,
  output logic [1:0]  timeout_err,
  output logic        stray_result,
  output logic [15:0] dispatch_count
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_WAIT = 2'd2} state_t;

  // index 0 = unit 01, index 1 = unit 10
  state_t      state_q [2];
  state_t      state_d [2];
  logic [3:0]  hold_q  [2];
  logic [3:0]  hold_d  [2];
  logic [15:0] wd_q    [2];
  logic [15:0] wd_d    [2];
  logic [15:0] wd_inc  [2];
  logic [1:0]  busy_v;
  logic [1:0]  res_hit;
  logic [1:0]  elig;
  logic [1:0]  grant;
  logic [1:0]  tmo_hit;
  logic        last_q;   // 1 = unit 10 was granted last

  assign busy_v     = {busy10, busy01};
  assign res_hit[0] = rgResultReady && (rgResultSource == 2'b01);
  assign res_hit[1] = rgResultReady && (rgResultSource == 2'b10);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= S_IDLE;
        hold_q[i]  <= 4'd0;
        wd_q[i]    <= 16'd0;
      end
      raygroup01      <= 2'b00;
      raygroup10      <= 2'b00;
      raygroupvalid01 <= 1'b0;
      raygroupvalid10 <= 1'b0;
      timeout_err     <= 2'b00;
      stray_result    <= 1'b0;
      dispatch_count  <= 16'd0;
      last_q          <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
        wd_q[i]    <= wd_d[i];
      end
      if (grant[0]) raygroup01 <= req_group;
      if (grant[1]) raygroup10 <= req_group;
      raygroupvalid01 <= grant[0];
      raygroupvalid10 <= grant[1];
      timeout_err     <= timeout_err | tmo_hit;
      if ((res_hit[0] && state_q[0] == S_IDLE) || (res_hit[1] && state_q[1] == S_IDLE))
        stray_result <= 1'b1;
      if (|grant) begin
        dispatch_count <= dispatch_count + 16'd1;
        last_q         <= grant[1];
      end
    end
  end

  // A result outranks a same-cycle timeout so no error is flagged for it.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
      wd_d[i]    = wd_q[i];
      wd_inc[i]  = wd_q[i] + 16'd1;
      tmo_hit[i] = 1'b0;
      case (state_q[i])
        S_IDLE: begin
          if (grant[i]) begin
            state_d[i] = S_HOLD;
            hold_d[i]  = 4'(HOLDOFF);
            wd_d[i]    = 16'd0;
          end
        end
        S_HOLD, S_WAIT: begin
          if (res_hit[i]) begin
            state_d[i] = S_IDLE;
            hold_d[i]  = 4'd0;
            wd_d[i]    = 16'd0;
          end else if (wd_inc[i] == 16'(TIMEOUT)) begin
            state_d[i] = S_IDLE;
            hold_d[i]  = 4'd0;
            wd_d[i]    = 16'd0;
            tmo_hit[i] = 1'b1;
          end else begin
            wd_d[i] = wd_inc[i];
            if (state_q[i] == S_HOLD) begin
              hold_d[i] = hold_q[i] - 4'd1;
              if (hold_q[i] == 4'd1) state_d[i] = S_WAIT;
            end
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          hold_d[i]  = 4'd0;
          wd_d[i]    = 16'd0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++)
      elig[i] = reset && enable && (state_q[i] == S_IDLE) && !busy_v[i];
    req_ready = |elig;
    idle      = !reset || (state_q[0] == S_IDLE && state_q[1] == S_IDLE);
    grant     = 2'b00;
    if (req_valid && req_ready) begin
      if (elig[0] && (!elig[1] || last_q)) grant = 2'b01;
      else                                 grant = 2'b10;
    end
  end

endmodule

// File: tb/tb_raygroup_dispatch_arbiter.sv
// tb/tb_raygroup_dispatch_arbiter.sv - directed bench for raygroup_dispatch_arbiter
module tb_raygroup_dispatch_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        req_valid;
  logic [1:0]  req_group;
  logic        req_ready;
  logic [1:0]  raygroup01;
  logic        raygroupvalid01;
  logic        busy01;
  logic [1:0]  raygroup10;
  logic        raygroupvalid10;
  logic        busy10;
  logic        rgResultReady;
  logic [1:0]  rgResultSource;
  logic        idle;
  logic [1:0]  timeout_err;
  logic        stray_result;
  logic [15:0] dispatch_count;

  int errors = 0;
  int checks = 0;

  logic       rv_t  [6];
  logic [1:0] grp_t [6];
  logic [1:0] res_t [6];
  logic [1:0] exp_t [6];

  always #5 clk = ~clk;

  raygroup_dispatch_arbiter #(.HOLDOFF(2), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_group(req_group), .req_ready(req_ready),
    .raygroup01(raygroup01), .raygroupvalid01(raygroupvalid01), .busy01(busy01),
    .raygroup10(raygroup10), .raygroupvalid10(raygroupvalid10), .busy10(busy10),
    .rgResultReady(rgResultReady), .rgResultSource(rgResultSource),
    .idle(idle), .timeout_err(timeout_err), .stray_result(stray_result),
    .dispatch_count(dispatch_count)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic [1:0] src);
    rgResultReady  = (src != 2'b00);
    rgResultSource = src;
  endtask

  initial begin
    rv_t  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    grp_t = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd0};
    res_t = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    exp_t = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};

    reset = 1'b0; enable = 1'b1; req_valid = 1'b1; req_group = 2'b00;
    busy01 = 1'b0; busy10 = 1'b0; drive_res(2'b00);
    tick(); tick();
    check("rst_idle", 16'(idle), 16'd1);
    check("rst_ready", 16'(req_ready), 16'd0);
    check("rst_count", dispatch_count, 16'd0);
    check("rst_valid", 16'({raygroupvalid10, raygroupvalid01}), 16'd0);
    check("rst_rg", 16'({raygroup10, raygroup01}), 16'd0);
    check("rst_flags", 16'({stray_result, timeout_err}), 16'd0);

    // first grant after reset goes to unit 01
    reset = 1'b1; req_group = 2'b11;
    #1 check("first_ready", 16'(req_ready), 16'd1);
    tick();
    req_valid = 1'b0;
    check("first_valid01", 16'(raygroupvalid01), 16'd1);
    check("first_valid10", 16'(raygroupvalid10), 16'd0);
    check("first_rg01", 16'(raygroup01), 16'd3);
    check("first_count", dispatch_count, 16'd1);
    tick();
    check("first_pulse_end", 16'(raygroupvalid01), 16'd0);
    drive_res(2'b01);
    tick();
    drive_res(2'b00);
    check("first_idle", 16'(idle), 16'd1);
    check("first_flags", 16'({stray_result, timeout_err}), 16'd0);

    // reset again so the pointer is back at unit 10
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rerst_count", dispatch_count, 16'd0);
    for (int k = 0; k < 6; k++) begin
      req_valid = rv_t[k]; req_group = grp_t[k]; drive_res(res_t[k]);
      #1 if (k == 2) check("rr_ready_both_busy", 16'(req_ready), 16'd0);
      tick();
      check($sformatf("rr_pulse%0d", k), 16'({raygroupvalid10, raygroupvalid01}), 16'(exp_t[k]));
    end
    drive_res(2'b00); req_valid = 1'b0;
    check("rr_count", dispatch_count, 16'd4);
    check("rr_rg01", 16'(raygroup01), 16'd3);
    check("rr_rg10", 16'(raygroup10), 16'd2);
    check("rr_idle", 16'(idle), 16'd1);
    check("rr_flags", 16'({stray_result, timeout_err}), 16'd0);

    // unit 01 busy: everything goes to unit 10
    busy01 = 1'b1; req_valid = 1'b1; req_group = 2'd1;
    #1 check("busy_ready", 16'(req_ready), 16'd1);
    tick();
    check("busy_grant1", 16'({raygroupvalid10, raygroupvalid01}), 16'b10);
    tick();
    check("busy_ready_hold", 16'(req_ready), 16'd0);
    tick();
    check("busy_ready_wait", 16'(req_ready), 16'd0);
    check("busy_no_pulse", 16'({raygroupvalid10, raygroupvalid01}), 16'd0);
    drive_res(2'b10);
    tick();
    drive_res(2'b00);
    check("busy_no_regrant", 16'({raygroupvalid10, raygroupvalid01}), 16'd0);
    #1 check("busy_ready_again", 16'(req_ready), 16'd1);
    tick();
    check("busy_grant2", 16'({raygroupvalid10, raygroupvalid01}), 16'b10);
    req_valid = 1'b0; drive_res(2'b10);
    tick();
    drive_res(2'b00); busy01 = 1'b0;
    check("busy_idle", 16'(idle), 16'd1);

    // watchdog: no result after a grant to unit 01
    req_valid = 1'b1; req_group = 2'd2;
    tick();
    req_valid = 1'b0;
    check("tmo_grant", 16'({raygroupvalid10, raygroupvalid01}), 16'b01);
    repeat (7) tick();
    check("tmo_not_yet_idle", 16'(idle), 16'd0);
    check("tmo_not_yet_err", 16'(timeout_err), 16'd0);
    tick();
    check("tmo_idle", 16'(idle), 16'd1);
    check("tmo_err", 16'(timeout_err), 16'b01);

    // result for an idle unit
    drive_res(2'b10);
    tick();
    drive_res(2'b00);
    check("stray_flag", 16'(stray_result), 16'd1);
    check("stray_idle", 16'(idle), 16'd1);

    // enable dropped while unit 01 is in flight
    busy10 = 1'b1; req_valid = 1'b1; req_group = 2'd1;
    tick();
    check("en_grant", 16'({raygroupvalid10, raygroupvalid01}), 16'b01);
    enable = 1'b0; busy10 = 1'b0;
    tick(); tick();
    check("en_ready", 16'(req_ready), 16'd0);
    check("en_no_pulse", 16'({raygroupvalid10, raygroupvalid01}), 16'd0);
    check("en_busy_idle", 16'(idle), 16'd0);
    drive_res(2'b01);
    tick();
    drive_res(2'b00);
    check("en_idle", 16'(idle), 16'd1);
    check("en_ready_after", 16'(req_ready), 16'd0);
    check("en_count", dispatch_count, 16'd8);
    check("en_err_kept", 16'(timeout_err), 16'b01);
    req_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
